// File: rtl/bcd_countdown_timer_pkg.sv
// bcd_countdown_timer_pkg
//   Shared definitions for the MM:SS BCD countdown timer:
//   digit width, per-digit BCD limits, FSM state type and a load-value
//   validity helper.
package bcd_countdown_timer_pkg;

  localparam int unsigned BCD_W = 4;

  localparam logic [BCD_W-1:0] DIGIT_MAX_9 = 4'd9;  // sec_u, min_u, min_t
  localparam logic [BCD_W-1:0] DIGIT_MAX_5 = 4'd5;  // sec_t

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_ALARM  = 2'b11
  } state_e;

  // {min_t,min_u,sec_t,sec_u}: every digit <= 9 and sec_t <= 5
  function automatic logic bcd_time_valid(input logic [4*BCD_W-1:0] v);
    return (v[15:12] <= DIGIT_MAX_9) && (v[11:8] <= DIGIT_MAX_9) &&
           (v[7:4]   <= DIGIT_MAX_5) && (v[3:0]  <= DIGIT_MAX_9);
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit
//   Mod-N down counter for one BCD digit. Load has priority over count.
//   Ports:
//     clk     in   clock
//     rstn    in   asynchronous reset, active-high (legacy name kept)
//     en      in   decrement enable
//     ld      in   load ld_val
//     ld_val  in   value to load
//     q       out  current digit
//     borrow  out  combinational: digit is 0 and being decremented
module bcd_down_digit
  import bcd_countdown_timer_pkg::*;
#(
  parameter int unsigned N = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             ld,
  input  logic [BCD_W-1:0] ld_val,
  output logic [BCD_W-1:0] q,
  output logic             borrow
);

  localparam logic [BCD_W-1:0] TOP = BCD_W'(N - 1);

  logic [BCD_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = ld_val;
    end else if (en) begin
      q_d = (q_q == '0) ? TOP : q_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign borrow = (q_q == '0) && en;

endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
//   Loadable MM:SS BCD countdown timer. Counts down one second per tick,
//   pulses expired on reaching 00:00, then holds alarm for ALARM_TICKS
//   ticks before returning to IDLE.
//   Ports:
//     clk       in   system clock
//     rstn      in   asynchronous reset, active-high (legacy name kept)
//     tick      in   1-cycle 1 Hz enable
//     load      in   load load_bcd (pulse)
//     load_bcd  in   {min_t,min_u,sec_t,sec_u}
//     start     in   begin/resume countdown (pulse)
//     pause     in   hold countdown (pulse)
//     clear     in   abort to IDLE with 00:00 (pulse)
//     bcd_out   out  current {min_t,min_u,sec_t,sec_u}
//     running   out  high in RUN
//     expired   out  1-cycle pulse on reaching 00:00
//     alarm     out  high in ALARM
//     load_err  out  1-cycle pulse on a rejected load
//   Control priority: clear > load > pause > start > tick. A load always
//   claims its cycle, even when rejected; start/pause only claim it when
//   they take effect.
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] load_bcd,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  output logic [15:0] bcd_out,
  output logic        running,
  output logic        expired,
  output logic        alarm,
  output logic        load_err
);

  localparam logic [7:0] ALARM_LAST = 8'(ALARM_TICKS - 1);

  state_e     state_q, state_d;
  logic [7:0] acnt_q, acnt_d;
  logic       running_q, expired_q, alarm_q, load_err_q;

  logic [BCD_W-1:0] su_q, st_q, mu_q, mt_q;
  logic             su_borrow, st_borrow, mu_borrow, mt_borrow;
  logic             dec, dig_ld, expire, lerr;
  logic [15:0]      dig_ld_val, cur;
  logic             value_nz, at_one;

  assign cur      = {mt_q, mu_q, st_q, su_q};
  assign value_nz = (cur != '0);
  assign at_one   = (cur == 16'h0001);

  // Kept outside the FSM block so the borrow chain can feed back into it
  // without forming a combinational loop.
  assign dec = (state_q == ST_RUN) && tick && !clear && !load && !pause;

  bcd_down_digit #(.N(10)) u_sec_u (
    .clk(clk), .rstn(rstn), .en(dec), .ld(dig_ld),
    .ld_val(dig_ld_val[3:0]), .q(su_q), .borrow(su_borrow)
  );

  bcd_down_digit #(.N(6)) u_sec_t (
    .clk(clk), .rstn(rstn), .en(su_borrow), .ld(dig_ld),
    .ld_val(dig_ld_val[7:4]), .q(st_q), .borrow(st_borrow)
  );

  bcd_down_digit #(.N(10)) u_min_u (
    .clk(clk), .rstn(rstn), .en(st_borrow), .ld(dig_ld),
    .ld_val(dig_ld_val[11:8]), .q(mu_q), .borrow(mu_borrow)
  );

  bcd_down_digit #(.N(10)) u_min_t (
    .clk(clk), .rstn(rstn), .en(mu_borrow), .ld(dig_ld),
    .ld_val(dig_ld_val[15:12]), .q(mt_q), .borrow(mt_borrow)
  );

  always_comb begin
    state_d    = state_q;
    acnt_d     = acnt_q;
    dig_ld     = 1'b0;
    dig_ld_val = '0;
    expire     = 1'b0;
    lerr       = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      dig_ld  = 1'b1;
      acnt_d  = '0;
    end else if (load) begin
      if (state_q == ST_RUN || !bcd_time_valid(load_bcd)) begin
        lerr = 1'b1;
      end else begin
        dig_ld     = 1'b1;
        dig_ld_val = load_bcd;
        if (state_q == ST_ALARM) state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE, ST_PAUSED: begin
          if (start && value_nz) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (tick && (at_one || mt_borrow)) begin
            // Forcing zeros stops min_t from ever wrapping to 9.
            expire  = 1'b1;
            dig_ld  = 1'b1;
            state_d = ST_ALARM;
            acnt_d  = '0;
          end
        end
        ST_ALARM: begin
          if (tick) begin
            if (acnt_q == ALARM_LAST) begin
              state_d = ST_IDLE;
              acnt_d  = '0;
            end else begin
              acnt_d = acnt_q + 8'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q    <= ST_IDLE;
      acnt_q     <= '0;
      running_q  <= 1'b0;
      expired_q  <= 1'b0;
      alarm_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acnt_q     <= acnt_d;
      running_q  <= (state_d == ST_RUN);
      expired_q  <= expire;
      alarm_q    <= (state_d == ST_ALARM);
      load_err_q <= lerr;
    end
  end

  assign bcd_out  = cur;
  assign running  = running_q;
  assign expired  = expired_q;
  assign alarm    = alarm_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer
//   Directed scenarios followed by randomized control traffic, checked
//   every cycle against a seconds-based reference model.
module tb_bcd_countdown_timer;

  localparam int unsigned AT = 10;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_ALARM  = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        tick = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_bcd = '0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] bcd_out;
  logic        running, expired, alarm, load_err;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.ALARM_TICKS(AT)) dut (
    .clk(clk), .rstn(rstn), .tick(tick), .load(load), .load_bcd(load_bcd),
    .start(start), .pause(pause), .clear(clear), .bcd_out(bcd_out),
    .running(running), .expired(expired), .alarm(alarm), .load_err(load_err)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: remaining time kept as plain seconds.
  int m_secs, m_mode, m_acnt;
  bit m_exp, m_lerr;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_secs = 0; m_mode = M_IDLE; m_acnt = 0; m_exp = 0; m_lerr = 0;
  endtask

  task automatic model_step(input bit t, input bit ld, input logic [15:0] v,
                            input bit s, input bit p, input bit c);
    int mt, mu, st, su;
    mt = int'(v[15:12]); mu = int'(v[11:8]); st = int'(v[7:4]); su = int'(v[3:0]);
    m_exp = 0; m_lerr = 0;
    if (c) begin
      m_secs = 0; m_mode = M_IDLE; m_acnt = 0;
    end else if (ld) begin
      if (m_mode == M_RUN || mt > 9 || mu > 9 || st > 5 || su > 9) begin
        m_lerr = 1;
      end else begin
        m_secs = mt * 600 + mu * 60 + st * 10 + su;
        if (m_mode == M_ALARM) m_mode = M_IDLE;
      end
    end else if (m_mode == M_IDLE || m_mode == M_PAUSED) begin
      if (s && m_secs != 0) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (p) m_mode = M_PAUSED;
      else if (t) begin
        m_secs = m_secs - 1;
        if (m_secs == 0) begin
          m_exp = 1; m_mode = M_ALARM; m_acnt = 0;
        end
      end
    end else begin
      if (t) begin
        m_acnt++;
        if (m_acnt == int'(AT)) begin
          m_mode = M_IDLE; m_acnt = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".bcd"},  bcd_out,          to_bcd(m_secs));
    check({tag, ".run"},  16'(running),     16'(m_mode == M_RUN));
    check({tag, ".exp"},  16'(expired),     16'(m_exp));
    check({tag, ".alm"},  16'(alarm),       16'(m_mode == M_ALARM));
    check({tag, ".lerr"}, 16'(load_err),    16'(m_lerr));
  endtask

  task automatic cyc(input string tag, input bit t, input bit ld, input logic [15:0] v,
                     input bit s, input bit p, input bit c);
    @(negedge clk);
    tick = t; load = ld; load_bcd = v; start = s; pause = p; clear = c;
    model_step(t, ld, v, s, p, c);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    tick = 0; load = 0; start = 0; pause = 0; clear = 0;
    #2 rstn = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rstn = 1'b0;
  endtask

  function automatic logic [15:0] rand_load();
    int k;
    k = int'($urandom_range(7, 0));
    if (k == 0) return 16'($urandom);
    if (k <= 4) return to_bcd(int'($urandom_range(20, 1)));
    return to_bcd(int'($urandom_range(5999, 0)));
  endfunction

  initial begin
    model_reset();
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rstn = 1'b0;

    // 01:00 -> 00:59
    cyc("t1_ld", 0, 1, 16'h0100, 0, 0, 0);
    cyc("t1_st", 0, 0, '0, 1, 0, 0);
    cyc("t1_tk", 1, 0, '0, 0, 0, 0);
    check("t1_0059", bcd_out, 16'h0059);
    check("t1_running", 16'(running), 16'd1);

    // full borrow chain 10:00 -> 09:59
    cyc("t2_clr", 0, 0, '0, 0, 0, 1);
    cyc("t2_ld", 0, 1, 16'h1000, 0, 0, 0);
    cyc("t2_st", 0, 0, '0, 1, 0, 0);
    cyc("t2_tk", 1, 0, '0, 0, 0, 0);
    check("t2_0959", bcd_out, 16'h0959);
    cyc("t2_ldrun", 0, 1, 16'h0001, 0, 0, 0);
    check("t2_lerr_run", 16'(load_err), 16'd1);

    // expiry and alarm duration
    cyc("t3_clr", 0, 0, '0, 0, 0, 1);
    cyc("t3_ld", 0, 1, 16'h0002, 0, 0, 0);
    cyc("t3_st", 0, 0, '0, 1, 0, 0);
    cyc("t3_tk1", 1, 0, '0, 0, 0, 0);
    cyc("t3_tk2", 1, 0, '0, 0, 0, 0);
    check("t3_expired", 16'(expired), 16'd1);
    check("t3_zero", bcd_out, 16'h0000);
    cyc("t3_idle", 0, 0, '0, 1, 1, 0);
    check("t3_exp_once", 16'(expired), 16'd0);
    for (int unsigned i = 0; i < AT; i++) cyc("t3_atk", 1, 0, '0, 0, 0, 0);
    check("t3_alarm_off", 16'(alarm), 16'd0);

    // pause discards same-cycle tick
    cyc("t4_ld", 0, 1, 16'h0031, 0, 0, 0);
    cyc("t4_st", 0, 0, '0, 1, 0, 0);
    cyc("t4_tk", 1, 0, '0, 0, 0, 0);
    cyc("t4_pz", 1, 0, '0, 0, 1, 0);
    check("t4_hold", bcd_out, 16'h0030);
    cyc("t4_tkp", 1, 0, '0, 0, 0, 0);
    cyc("t4_st2", 0, 0, '0, 1, 0, 0);
    cyc("t4_tk2", 1, 0, '0, 0, 0, 0);
    check("t4_0029", bcd_out, 16'h0029);

    // invalid load, zero start
    cyc("t5_clr", 0, 0, '0, 0, 0, 1);
    cyc("t5_ld", 0, 1, 16'h0123, 0, 0, 0);
    cyc("t5_bad", 0, 1, 16'h0070, 0, 0, 0);
    check("t5_lerr", 16'(load_err), 16'd1);
    check("t5_keep", bcd_out, 16'h0123);
    cyc("t5_ld0", 0, 1, 16'h0000, 0, 0, 0);
    cyc("t5_st0", 1, 0, '0, 1, 0, 0);
    check("t5_norun", 16'(running), 16'd0);

    // async reset mid-run
    cyc("t6_ld", 0, 1, 16'h0546, 0, 0, 0);
    cyc("t6_st", 0, 0, '0, 1, 0, 0);
    cyc("t6_tk", 1, 0, '0, 0, 0, 0);
    async_reset("t6_rst");
    check("t6_zero", bcd_out, 16'h0000);

    // clear during alarm
    cyc("t7_ld", 0, 1, 16'h0001, 0, 0, 0);
    cyc("t7_st", 0, 0, '0, 1, 0, 0);
    cyc("t7_tk", 1, 0, '0, 0, 0, 0);
    check("t7_alarm", 16'(alarm), 16'd1);
    cyc("t7_clr", 1, 0, '0, 0, 0, 1);
    check("t7_alarm_off", 16'(alarm), 16'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(599, 0) == 0) begin
        async_reset("r_rst");
      end else begin
        cyc("rnd",
            $urandom_range(1, 0) == 1,
            $urandom_range(11, 0) == 0,
            rand_load(),
            $urandom_range(5, 0) == 0,
            $urandom_range(19, 0) == 0,
            $urandom_range(79, 0) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
